dac_sample_streamer: RTL and testbench

//  Transmit-side counterpart of the ADC capture path. Accepts processed two-channel 14-bit samples

---
 rtl/dac_streamer_pkg.sv | 20 ++
 rtl/dac_sample_fifo.sv | 56 +++++
 rtl/dac_sample_streamer.sv | 122 ++++++++++++
 tb/tb_dac_sample_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_streamer_pkg.sv
// Shared types and constants for the DAC sample streamer.
// No logic; imported by the FIFO and the top level.
// No handshakes live here.
package dac_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_INIT,
        PRIME,
        RUN
    } state_t;

    localparam logic [3:0] IAGC_STATUS_RESET = 4'b0000;

    // Address bits needed for a power-of-two FIFO; pointers carry one extra wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample-pair FIFO with wrap-bit pointers and a synchronous flush.
// Latency: a pushed entry is readable the cycle after the push; read data is the head, combinationally.
// Backpressure: push is ignored when full, pop ignored when empty; flush wins over both.
module dac_sample_fifo
    import dac_streamer_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH):0]   level
);

    localparam int AW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    // Same slot but different lap means every entry is occupied.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/dac_sample_streamer.sv
// Buffers two-channel DAC samples and issues them to the Zmod DAC controller at a programmable rate.
// Latency: a popped pair appears on o_dac_data_* one cycle after its rate tick.
// Backpressure: o_sample_ready drops when the FIFO is full or the stream is idle.
module dac_sample_streamer
    import dac_streamer_pkg::*;
#(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int FIFO_DEPTH       = 16,
    parameter int RATE_DIV_SIZE    = 16
) (
    input  logic                              i_sys_clock,
    input  logic                              i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0]       i_iagc_status,
    input  logic                              i_dac_init_done,
    input  logic [RATE_DIV_SIZE-1:0]          i_rate_div,
    input  logic [ZMOD_DATA_SIZE-1:0]         i_sample_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0]         i_sample_ch2,
    input  logic                              i_sample_valid,
    output logic                              o_sample_ready,
    output logic [ZMOD_DATA_SIZE-1:0]         o_dac_data_ch1,
    output logic [ZMOD_DATA_SIZE-1:0]         o_dac_data_ch2,
    output logic                              o_dac_data_valid,
    output logic                              o_dac_enable,
    output logic                              o_underrun,
    output logic [ptr_width(FIFO_DEPTH):0]    o_fifo_level
);

    localparam int LW = ptr_width(FIFO_DEPTH) + 1;
    localparam int PW = 2 * ZMOD_DATA_SIZE;
    localparam logic [LW-1:0] PRIME_LEVEL = LW'(FIFO_DEPTH / 2);

    state_t                   state;
    state_t                   state_nxt;
    logic [RATE_DIV_SIZE-1:0] rate_cnt;
    logic                     stream_off;
    logic                     tick;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [PW-1:0]            fifo_rdata;

    assign stream_off = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_RESET));
    assign push       = i_sample_valid & o_sample_ready;
    assign pop        = tick & ~fifo_empty;

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stream_off) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_INIT;
                WAIT_INIT: if (i_dac_init_done) state_nxt = PRIME;
                PRIME: begin
                    if (!i_dac_init_done)                state_nxt = WAIT_INIT;
                    else if (o_fifo_level >= PRIME_LEVEL) state_nxt = RUN;
                end
                RUN: begin
                    if (!i_dac_init_done)        state_nxt = WAIT_INIT;
                    else if (tick && fifo_empty) state_nxt = PRIME;
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Ticks are suppressed on the cycle the stream is leaving RUN so nothing is popped on the way out.
    always_comb begin
        o_dac_enable   = (state == RUN);
        o_sample_ready = (state != IDLE) && !fifo_full;
        tick           = (state == RUN) && (rate_cnt == '0) && i_dac_init_done && !stream_off;
    end

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n)           rate_cnt <= '0;
        else if (state != RUN)    rate_cnt <= i_rate_div;
        else if (rate_cnt == '0)  rate_cnt <= i_rate_div;
        else                      rate_cnt <= rate_cnt - RATE_DIV_SIZE'(1);
    end

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dac_data_ch1   <= '0;
            o_dac_data_ch2   <= '0;
            o_dac_data_valid <= 1'b0;
            o_underrun       <= 1'b0;
        end else if (stream_off) begin
            o_dac_data_ch1   <= '0;
            o_dac_data_ch2   <= '0;
            o_dac_data_valid <= 1'b0;
            o_underrun       <= 1'b0;
        end else begin
            o_dac_data_valid <= pop;
            if (pop) {o_dac_data_ch1, o_dac_data_ch2} <= fifo_rdata;
            if (tick && fifo_empty) o_underrun <= 1'b1;
        end
    end

    dac_sample_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_sys_clock),
        .rst_n (i_reset_n),
        .flush (stream_off || (state == IDLE)),
        .push  (push),
        .wdata ({i_sample_ch1, i_sample_ch2}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_fifo_level)
    );

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Bench for dac_sample_streamer: a cycle model tracks mode/level/rate, a queue holds accepted pairs
// and a negedge monitor pops it whenever the DUT strobes valid.
module tb_dac_sample_streamer;

    localparam int DW = 14;
    localparam int SW = 4;
    localparam int DEPTH = 16;
    localparam int RW = 16;
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PRIME = 2;
    localparam int M_RUN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] status = '0;
    logic          init_done = 1'b0;
    logic [RW-1:0] rate_div = '0;
    logic [DW-1:0] ch1 = '0;
    logic [DW-1:0] ch2 = '0;
    logic          svalid = 1'b0;

    logic          o_sample_ready;
    logic [DW-1:0] o_dac_data_ch1;
    logic [DW-1:0] o_dac_data_ch2;
    logic          o_dac_data_valid;
    logic          o_dac_enable;
    logic          o_underrun;
    logic [4:0]    o_fifo_level;

    dac_sample_streamer dut (
        .i_sys_clock      (clk),
        .i_reset_n        (rst_n),
        .i_iagc_status    (status),
        .i_dac_init_done  (init_done),
        .i_rate_div       (rate_div),
        .i_sample_ch1     (ch1),
        .i_sample_ch2     (ch2),
        .i_sample_valid   (svalid),
        .o_sample_ready   (o_sample_ready),
        .o_dac_data_ch1   (o_dac_data_ch1),
        .o_dac_data_ch2   (o_dac_data_ch2),
        .o_dac_data_valid (o_dac_data_valid),
        .o_dac_enable     (o_dac_enable),
        .o_underrun       (o_underrun),
        .o_fifo_level     (o_fifo_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          m_mode = M_IDLE;
    int          m_level = 0;
    int          m_cnt = 0;
    bit          m_valid = 1'b0;
    bit          m_underrun = 1'b0;
    bit          m_pushed = 1'b0;
    logic [27:0] sb[$];
    logic [27:0] hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour evaluated once per rising edge from the inputs held across that edge.
    task automatic model_step();
        bit rdy;
        bit push;
        bit pop;
        if (!rst_n) begin
            m_mode = M_IDLE; m_level = 0; m_cnt = 0; m_valid = 0;
            m_underrun = 0; m_pushed = 0; sb.delete(); hold = '0;
            return;
        end
        rdy = (m_mode != M_IDLE) && (m_level < DEPTH);
        push = svalid && rdy;
        pop = 0;
        m_pushed = push;
        if (status == 0) begin
            m_mode = M_IDLE; m_level = 0; sb.delete(); hold = '0;
            m_valid = 0; m_underrun = 0; m_pushed = 0;
            return;
        end
        case (m_mode)
            M_IDLE: m_mode = M_WAIT;
            M_WAIT: if (init_done) m_mode = M_PRIME;
            M_PRIME: begin
                m_cnt = int'(rate_div);
                if (!init_done) m_mode = M_WAIT;
                else if (m_level >= DEPTH / 2) m_mode = M_RUN;
            end
            default: begin
                if (!init_done) m_mode = M_WAIT;
                else if (m_cnt > 0) m_cnt--;
                else begin
                    m_cnt = int'(rate_div);
                    if (m_level == 0) begin
                        m_underrun = 1;
                        m_mode = M_PRIME;
                    end else pop = 1;
                end
            end
        endcase
        m_valid = pop;
        if (push) sb.push_back({ch1, ch2});
        m_level = m_level + int'(push) - int'(pop);
    endtask

    task automatic monitor();
        check("ready", o_sample_ready, (m_mode != M_IDLE) && (m_level < DEPTH));
        check("level", o_fifo_level, m_level);
        check("enable", o_dac_enable, m_mode == M_RUN);
        check("underrun", o_underrun, m_underrun);
        check("valid", o_dac_data_valid, m_valid);
        if (o_dac_data_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_order: got strobe with data %0h, required no strobe (nothing queued) at %0t",
                         {o_dac_data_ch1, o_dac_data_ch2}, $time);
            end else hold = sb.pop_front();
        end
        check("data", {o_dac_data_ch1, o_dac_data_ch2}, hold);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) monitor();
    end

    task automatic push_seq(input int n, input bit rand_data);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 400) begin
            if (rand_data) begin
                ch1 = DW'($urandom);
                ch2 = DW'($urandom);
            end else begin
                ch1 = DW'(k + 1);
                ch2 = DW'(16384 - (k + 1));
            end
            svalid = 1'b1;
            @(negedge clk);
            guard++;
            if (m_pushed) k++;
        end
        svalid = 1'b0;
        check("push_seq_done", k, n);
    endtask

    task automatic stream_rand(input int n);
        repeat (n) begin
            ch1 = DW'($urandom);
            ch2 = DW'($urandom);
            svalid = 1'b1;
            @(negedge clk);
        end
        svalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, o_sample_ready, 0);
        check({tag, "_data"}, {o_dac_data_ch1, o_dac_data_ch2}, 0);
        check({tag, "_valid"}, o_dac_data_valid, 0);
        check({tag, "_enable"}, o_dac_enable, 0);
        check({tag, "_underrun"}, o_underrun, 0);
        check({tag, "_level"}, o_fifo_level, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Normal stream: eight known pairs, one strobe every 4 clocks, then underrun.
        status = 4'b0001; init_done = 1'b1; rate_div = 16'd3;
        push_seq(8, 0);
        repeat (60) @(negedge clk);

        // rate_div 0: one pair per clock, then underrun with the last pair held.
        status = 4'b0000;
        @(negedge clk);
        status = 4'b0001; rate_div = 16'd0;
        push_seq(8, 0);
        repeat (20) @(negedge clk);
        check("t3_underrun", o_underrun, 1);
        check("t3_hold", {o_dac_data_ch1, o_dac_data_ch2}, {14'h0008, 14'h3FF8});
        check("t3_enable", o_dac_enable, 0);
        check("t3_ready", o_sample_ready, 1);

        // Status flush with ten queued and a push in the same cycle.
        rate_div = 16'd1000;
        push_seq(10, 1);
        check("t5_level_pre", o_fifo_level, 10);
        status = 4'b0000; svalid = 1'b1; ch1 = DW'($urandom); ch2 = DW'($urandom);
        @(negedge clk);
        svalid = 1'b0;
        check_all_zero("t5");

        // Full back-pressure: stall the DAC after priming, keep offering data.
        status = 4'b0010; init_done = 1'b1; rate_div = 16'd300;
        push_seq(9, 1);
        init_done = 1'b0;
        stream_rand(20);
        check("t4_level_full", o_fifo_level, 16);
        check("t4_ready_full", o_sample_ready, 0);
        init_done = 1'b1; rate_div = 16'd0;
        stream_rand(30);
        repeat (40) @(negedge clk);

        // Rate change mid-RUN.
        status = 4'b0000;
        @(negedge clk);
        status = 4'b0100; rate_div = 16'd5;
        stream_rand(40);
        rate_div = 16'd1;
        stream_rand(40);
        repeat (30) @(negedge clk);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            status = ($urandom_range(0, 99) < 2) ? 4'b0000 : SW'($urandom_range(1, 15));
            init_done = ($urandom_range(0, 99) >= 4);
            rate_div = RW'($urandom_range(0, 3));
            svalid = ($urandom_range(0, 99) < 55);
            ch1 = DW'($urandom);
            ch2 = DW'($urandom);
            @(negedge clk);
        end
        svalid = 1'b0;

        // Reset asserted mid-run clears everything without waiting for a clock.
        status = 4'b0001; init_done = 1'b1; rate_div = 16'd2;
        @(negedge clk);
        push_seq(9, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t1_async");
        status = 4'b0000;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("t1_rel_ready", o_sample_ready, 0);
        check("t1_rel_enable", o_dac_enable, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
